// File: rtl/simple_cpu.sv
// Single-cycle 32-bit register-file datapath: manual load port plus one R-type op per clock.
// Registers r0..r7 are exported directly from the register array; OV is a registered overflow flag.
module simple_cpu (
    input  logic        clk,
    input  logic        reset,
    input  logic        WR,
    input  logic        LO,
    input  logic [2:0]  RSM,
    input  logic [31:0] ManIn,
    input  logic [31:0] INS,
    output logic        OV,
    output logic [31:0] reg1,
    output logic [31:0] reg2,
    output logic [31:0] reg3,
    output logic [31:0] reg4,
    output logic [31:0] reg5,
    output logic [31:0] reg6,
    output logic [31:0] reg7,
    output logic [31:0] reg8
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_NOP = 6'd0;
    localparam logic [OP_W-1:0] OP_AND = 6'd1;
    localparam logic [OP_W-1:0] OP_OR  = 6'd2;
    localparam logic [OP_W-1:0] OP_NOR = 6'd3;
    localparam logic [OP_W-1:0] OP_ADD = 6'd4;
    localparam logic [OP_W-1:0] OP_SUB = 6'd5;
    localparam logic [OP_W-1:0] OP_XOR = 6'd6;
    localparam logic [OP_W-1:0] OP_SLL = 6'd7;
    localparam logic [OP_W-1:0] OP_SRL = 6'd8;
    localparam logic [OP_W-1:0] OP_SLT = 6'd9;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              ov_q;
    logic              ov_d;

    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] sh;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] alu_res;
    logic              alu_wr;
    logic              alu_ov;
    logic              unused_funct_c;

    assign op  = INS[31:26];
    assign rs  = INS[25:21];
    assign rt  = INS[20:16];
    assign rd  = INS[15:11];
    assign sh  = INS[10:6];
    assign unused_funct_c = ^INS[5:0];

    assign rs_val = regs_q[rs];
    assign rt_val = regs_q[rt];
    assign sum    = rs_val + rt_val;
    assign diff   = rs_val - rt_val;

    // Instruction decode and execute; overflow derived from operand/result sign bits.
    always_comb begin
        alu_res = '0;
        alu_wr  = 1'b1;
        alu_ov  = 1'b0;
        case (op)
            OP_AND: alu_res = rs_val & rt_val;
            OP_OR:  alu_res = rs_val | rt_val;
            OP_NOR: alu_res = ~(rs_val | rt_val);
            OP_ADD: begin
                alu_res = sum;
                alu_ov  = (rs_val[DATA_W-1] == rt_val[DATA_W-1]) &&
                          (sum[DATA_W-1] != rs_val[DATA_W-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ov  = (rs_val[DATA_W-1] != rt_val[DATA_W-1]) &&
                          (diff[DATA_W-1] != rs_val[DATA_W-1]);
            end
            OP_XOR: alu_res = rs_val ^ rt_val;
            OP_SLL: alu_res = rt_val << sh;
            OP_SRL: alu_res = rt_val >> sh;
            OP_SLT: alu_res = DATA_W'($signed(rs_val) < $signed(rt_val));
            OP_NOP: alu_wr  = 1'b0;
            default: alu_wr = 1'b0;
        endcase
    end

    // Next-state for register file and flag.
    always_comb begin
        regs_d = regs_q;
        ov_d   = ov_q;
        if (WR) begin
            if (!LO) begin
                regs_d[ADDR_W'(RSM)] = ManIn;
            end else begin
                ov_d = alu_ov;
                if (alu_wr) begin
                    regs_d[rd] = alu_res;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            ov_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            ov_q   <= ov_d;
        end
    end

    assign OV   = ov_q;
    assign reg1 = regs_q[0];
    assign reg2 = regs_q[1];
    assign reg3 = regs_q[2];
    assign reg4 = regs_q[3];
    assign reg5 = regs_q[4];
    assign reg6 = regs_q[5];
    assign reg7 = regs_q[6];
    assign reg8 = regs_q[7];

endmodule

// File: tb/tb_simple_cpu.sv
// Directed test-plan steps followed by random instructions, checked against an arithmetic model.
module tb_simple_cpu;

    logic        clk = 1'b0;
    logic        reset;
    logic        WR;
    logic        LO;
    logic [2:0]  RSM;
    logic [31:0] ManIn;
    logic [31:0] INS;
    logic        OV;
    logic [31:0] reg1, reg2, reg3, reg4, reg5, reg6, reg7, reg8;
    logic [31:0] obs [8];

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] m_regs [32];
    logic        m_ov;

    always #5 clk = ~clk;

    simple_cpu dut (
        .clk   (clk),
        .reset (reset),
        .WR    (WR),
        .LO    (LO),
        .RSM   (RSM),
        .ManIn (ManIn),
        .INS   (INS),
        .OV    (OV),
        .reg1  (reg1),
        .reg2  (reg2),
        .reg3  (reg3),
        .reg4  (reg4),
        .reg5  (reg5),
        .reg6  (reg6),
        .reg7  (reg7),
        .reg8  (reg8)
    );

    assign obs[0] = reg1;
    assign obs[1] = reg2;
    assign obs[2] = reg3;
    assign obs[3] = reg4;
    assign obs[4] = reg5;
    assign obs[5] = reg6;
    assign obs[6] = reg7;
    assign obs[7] = reg8;

    function automatic logic [31:0] enc(input int op, input int rs, input int rt,
                                        input int rd, input int sh);
        enc = {6'(op), 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'd0};
    endfunction

    // Reference: what one clock edge does to the architectural state.
    task automatic model_edge(input logic rst, input logic wr, input logic lo,
                              input logic [2:0] rsm, input logic [31:0] man,
                              input logic [31:0] ins);
        int unsigned op, rs, rt, rd, sh;
        longint a, b, t;
        logic [31:0] ua, ub;
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = 0;
            m_ov = 0;
            return;
        end
        if (!wr) return;
        if (!lo) begin
            m_regs[rsm] = man;
            return;
        end
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6];
        ua = m_regs[rs]; ub = m_regs[rt];
        a = longint'($signed(ua)); b = longint'($signed(ub));
        m_ov = 0;
        case (op)
            1: m_regs[rd] = ua & ub;
            2: m_regs[rd] = ua | ub;
            3: m_regs[rd] = ~(ua | ub);
            4, 5: begin
                t = (op == 4) ? a + b : a - b;
                m_regs[rd] = t[31:0];
                m_ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            6: m_regs[rd] = ua ^ ub;
            7: m_regs[rd] = 32'(ub * (64'd1 << sh));
            8: m_regs[rd] = 32'(ub / (64'd1 << sh));
            9: m_regs[rd] = (a < b) ? 32'd1 : 32'd0;
            default: ;
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        compared++;
        assert (o === e) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++) check($sformatf("%s r%0d", tag, i), obs[i], m_regs[i]);
        check($sformatf("%s OV", tag), {31'd0, OV}, {31'd0, m_ov});
    endtask

    // Drive inputs away from the edge, clock once, update model, sample after the edge.
    task automatic step(input logic rst, input logic wr, input logic lo,
                        input logic [2:0] rsm, input logic [31:0] man, input logic [31:0] ins);
        @(negedge clk);
        reset = rst; WR = wr; LO = lo; RSM = rsm; ManIn = man; INS = ins;
        @(posedge clk);
        model_edge(rst, wr, lo, rsm, man, ins);
        #1;
    endtask

    task automatic load(input int r, input logic [31:0] v);
        step(0, 1, 0, 3'(r), v, 32'hFFFF_FFFF);
    endtask

    task automatic exec(input logic [31:0] ins);
        step(0, 1, 1, 3'($urandom), $urandom, ins);
    endtask

    task automatic mux_seq;
        exec(enc(3, 2, 2, 3, 0));
        exec(enc(1, 0, 3, 4, 0));
        exec(enc(1, 2, 1, 5, 0));
        exec(enc(2, 4, 5, 6, 0));
    endtask

    initial begin
        reset = 1; WR = 1; LO = 1; RSM = 0; ManIn = 0; INS = 0;
        foreach (m_regs[i]) m_regs[i] = 32'hDEAD_BEEF;
        m_ov = 1;

        step(1, 1, 1, 0, 0, enc(4, 0, 0, 1, 0));
        step(1, 1, 0, 3, 32'h1234, 0);
        check_all("reset");

        load(0, 32'd51); load(1, 32'd32); load(2, 32'd0);
        check_all("loads");
        check("load r0", reg1, 32'd51);

        mux_seq();
        check_all("mux s0");
        check("mux s0 r6", reg7, 32'd51);
        check("mux s0 r3", reg4, 32'hFFFF_FFFF);

        load(2, 32'hFFFF_FFFF);
        mux_seq();
        check_all("mux s1");
        check("mux s1 r6", reg7, 32'd32);
        check("mux s1 r3", reg4, 32'd0);

        load(0, 32'h7FFF_FFFF); load(1, 32'd1);
        exec(enc(4, 0, 1, 3, 0));
        check_all("add ovf");
        check("add ovf res", reg4, 32'h8000_0000);
        check("add ovf flag", {31'd0, OV}, 32'd1);
        exec(enc(4, 1, 1, 4, 0));
        check_all("add 1+1");
        check("add 1+1 res", reg5, 32'd2);
        exec(enc(5, 3, 1, 5, 0));
        check_all("sub ovf");
        check("sub ovf res", reg6, 32'h7FFF_FFFF);
        check("sub ovf flag", {31'd0, OV}, 32'd1);

        step(0, 0, 1, 0, 0, enc(4, 1, 1, 0, 0));
        check_all("wr0 op");
        step(0, 0, 0, 0, 32'h55, 0);
        check_all("wr0 load");
        check("wr0 ov hold", {31'd0, OV}, 32'd1);
        exec(enc(63, 1, 1, 2, 0));
        check_all("undef op");
        check("undef ov", {31'd0, OV}, 32'd0);
        exec(enc(7, 0, 1, 6, 31));
        check_all("sll31");
        check("sll31 res", reg7, 32'h8000_0000);
        exec(enc(9, 3, 1, 7, 0));
        check_all("slt");
        exec(enc(8, 0, 3, 0, 31));
        check_all("srl31");

        step(1, 1, 0, 0, 32'd5, 0);
        check_all("reset mid");
        check("reset mid r0", reg1, 32'd0);

        for (int n = 0; n < 400; n++) begin
            logic rst_r, wr_r, lo_r;
            int op_r;
            rst_r = ($urandom_range(0, 99) == 0);
            wr_r  = ($urandom_range(0, 7) != 0);
            lo_r  = ($urandom_range(0, 2) != 0);
            op_r  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 63))
                                                 : int'($urandom_range(0, 9));
            step(rst_r, wr_r, lo_r, 3'($urandom), $urandom,
                 enc(op_r, $urandom_range(0, 11), $urandom_range(0, 11),
                     $urandom_range(0, 11), $urandom_range(0, 31)));
            check_all($sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
